// File: rtl/dec_grant_sequencer.sv
// -----------------------------------------------------------------------------
// dec_grant_sequencer
//
// Four-requester round-robin grant sequencer feeding a 2:4 one-hot decoder.
// Each grant holds En high for at least HOLD_CYCLES cycles. Between any two
// grants En drops for exactly one GAP cycle (break-before-make), so the
// decoded grant lines never overlap or glitch when the select changes.
//
// Parameters
//   HOLD_CYCLES : minimum En-high cycles per grant (legal 1..255)
//
// Ports
//   clk  in  1 : rising-edge clock
//   rst  in  1 : asynchronous, active-high reset
//   req  in  4 : request levels, bit i requests channel i
//   done in  1 : current owner finished; only looked at while granting
//   w    out 2 : encoded index of the granted channel (registered)
//   En   out 1 : grant valid (registered)
//   busy out 1 : high while in GRANT or GAP (registered)
// -----------------------------------------------------------------------------
module dec_grant_sequencer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] w,
  output logic       En,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_t     state;
  logic [1:0] ptr;        // channel the next search starts from
  logic [7:0] cnt;        // remaining hold cycles after the current one
  logic       done_seen;  // done arrived earlier in this grant

  logic       arb_valid;
  logic [1:0] arb_idx;
  logic       release_now;

  // Round-robin search: first set request at ptr, ptr+1, ... (mod 4).
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    logic [1:0] cand;
    arb_valid = 1'b0;
    arb_idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (!arb_valid && req[cand]) begin
        arb_valid = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // A finished hold releases if the owner is done (now or earlier) or has
  // withdrawn its request; otherwise the grant is held with no timeout.
  assign release_now = (cnt == 8'd0) && (done_seen || done || !req[w]);

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      cnt       <= 8'd0;
      done_seen <= 1'b0;
      w         <= 2'd0;
      En        <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        // GAP closes with the same arbitration as IDLE; w is only updated
        // when a new grant starts, so it never moves while En is high.
        IDLE, GAP: begin
          if (arb_valid) begin
            w         <= arb_idx;
            En        <= 1'b1;
            busy      <= 1'b1;
            cnt       <= HOLD_LOAD;
            done_seen <= 1'b0;
            state     <= GRANT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        GRANT: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
            if (done) done_seen <= 1'b1;
          end else if (release_now) begin
            En    <= 1'b0;
            ptr   <= w + 2'd1;  // owner moves to the back of the rotation
            state <= GAP;
          end
        end

        default: begin
          En    <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dec_grant_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dec_grant_sequencer
//
// Directed bench for dec_grant_sequencer. One instance uses the default
// HOLD_CYCLES=4, a second uses HOLD_CYCLES=1. Inputs change 1 ns after a
// rising edge and outputs are sampled at the same point, so each step()
// reflects exactly one clock edge.
// -----------------------------------------------------------------------------
module tb_dec_grant_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [1:0] w;
  logic       En;
  logic       busy;

  logic [3:0] req1 = 4'b0000;
  logic       done1 = 1'b0;
  logic [1:0] w1;
  logic       En1;
  logic       busy1;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  dec_grant_sequencer #(.HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .w(w), .En(En), .busy(busy)
  );

  dec_grant_sequencer #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .done(done1),
    .w(w1), .En(En1), .busy(busy1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges (asynchronous on both assert and release).
  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({w, En, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_values: got w=%b En=%b busy=%b, want w=00 En=0 busy=0", w, En, busy);
    end
    rst = 1'b0;
    req = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if ({En, busy} !== 2'b00) begin
        errors++;
        $display("FAIL idle_no_req[%0d]: got En=%b busy=%b, want En=0 busy=0", i, En, busy);
      end
    end
  endtask

  task automatic test_single_early_done();
    pulse_reset();
    req = 4'b0100;
    step();                         // edge 1: grant
    vectors++;
    if ({w, En, busy} !== 4'b1011) begin
      errors++;
      $display("FAIL single_grant: got w=%b En=%b busy=%b, want w=10 En=1 busy=1", w, En, busy);
    end
    done = 1'b1;                    // done sampled at edge 2
    for (int e = 2; e <= 4; e++) begin
      step();
      done = 1'b0;
      if (e == 4) req = 4'b0000;
      vectors++;
      if ({w, En, busy} !== 4'b1011) begin
        errors++;
        $display("FAIL single_hold_e%0d: got w=%b En=%b busy=%b, want w=10 En=1 busy=1", e, w, En, busy);
      end
    end
    step();                         // edge 5: release into GAP
    vectors++;
    if ({w, En, busy} !== 4'b1001) begin
      errors++;
      $display("FAIL single_release: got w=%b En=%b busy=%b, want w=10 En=0 busy=1", w, En, busy);
    end
    step();                         // edge 6: back to IDLE
    vectors++;
    if ({w, En, busy} !== 4'b1000) begin
      errors++;
      $display("FAIL single_idle: got w=%b En=%b busy=%b, want w=10 En=0 busy=0", w, En, busy);
    end
  endtask

  task automatic test_full_contention();
    logic [1:0] exp_w;
    pulse_reset();
    req  = 4'b1111;
    done = 1'b1;
    for (int g = 0; g < 5; g++) begin
      exp_w = 2'(g);
      for (int c = 0; c < 4; c++) begin
        step();
        vectors++;
        if ({w, En, busy} !== {exp_w, 2'b11}) begin
          errors++;
          $display("FAIL contention_g%0d_c%0d: got w=%b En=%b busy=%b, want w=%b En=1 busy=1", g, c, w, En, busy, exp_w);
        end
      end
      if (g == 4) req = 4'b0000;
      step();
      vectors++;
      if ({w, En, busy} !== {exp_w, 2'b01}) begin
        errors++;
        $display("FAIL contention_gap%0d: got w=%b En=%b busy=%b, want w=%b En=0 busy=1", g, w, En, busy, exp_w);
      end
    end
    done = 1'b0;
  endtask

  task automatic test_wrap_skip();
    logic [1:0] exp_w [3];
    logic [3:0] next_req [3];
    exp_w    = '{2'd3, 2'd1, 2'd0};
    next_req = '{4'b0010, 4'b0001, 4'b0000};
    pulse_reset();
    req  = 4'b1000;
    done = 1'b1;
    for (int g = 0; g < 3; g++) begin
      step();
      vectors++;
      if ({w, En, busy} !== {exp_w[g], 2'b11}) begin
        errors++;
        $display("FAIL wrap_grant%0d: got w=%b En=%b busy=%b, want w=%b En=1 busy=1", g, w, En, busy, exp_w[g]);
      end
      repeat (3) step();
      step();                       // release into GAP
      vectors++;
      if ({En, busy} !== 2'b01) begin
        errors++;
        $display("FAIL wrap_gap%0d: got En=%b busy=%b, want En=0 busy=1", g, En, busy);
      end
      req = next_req[g];            // changed before the GAP arbitration edge
    end
    done = 1'b0;
    step();
    vectors++;
    if ({En, busy} !== 2'b00) begin
      errors++;
      $display("FAIL wrap_idle: got En=%b busy=%b, want En=0 busy=0", En, busy);
    end
  endtask

  task automatic test_drop_and_stuck();
    pulse_reset();
    req = 4'b0001;
    step();                         // grant
    step();                         // first hold edge
    req = 4'b0000;                  // owner withdraws early
    step();
    step();
    vectors++;
    if ({w, En} !== 3'b001) begin
      errors++;
      $display("FAIL drop_still_held: got w=%b En=%b, want w=00 En=1", w, En);
    end
    step();                         // hold over, req[0] low -> release
    vectors++;
    if ({En, busy} !== 2'b01) begin
      errors++;
      $display("FAIL drop_release: got En=%b busy=%b, want En=0 busy=1", En, busy);
    end
    step();
    // Stuck owner: request held, done never arrives.
    req = 4'b0001;
    step();
    for (int i = 0; i < 24; i++) begin
      step();
      vectors++;
      if ({w, En, busy} !== 4'b0011) begin
        errors++;
        $display("FAIL stuck_held[%0d]: got w=%b En=%b busy=%b, want w=00 En=1 busy=1", i, w, En, busy);
      end
    end
    done = 1'b1;
    req  = 4'b0000;
    step();
    done = 1'b0;
    vectors++;
    if ({En, busy} !== 2'b01) begin
      errors++;
      $display("FAIL stuck_release: got En=%b busy=%b, want En=0 busy=1", En, busy);
    end
    step();
  endtask

  task automatic test_async_reset_and_hold1();
    pulse_reset();
    req = 4'b0100;
    step();
    step();
    vectors++;
    if ({w, En} !== 3'b101) begin
      errors++;
      $display("FAIL areset_pre: got w=%b En=%b, want w=10 En=1", w, En);
    end
    #2;
    rst = 1'b1;                     // mid-cycle, no clock edge involved
    #1;
    vectors++;
    if ({w, En, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL areset_immediate: got w=%b En=%b busy=%b, want w=00 En=0 busy=0", w, En, busy);
    end
    rst = 1'b0;
    req = 4'b1001;
    step();
    vectors++;
    if ({w, En, busy} !== 4'b0011) begin
      errors++;
      $display("FAIL areset_regrant: got w=%b En=%b busy=%b, want w=00 En=1 busy=1", w, En, busy);
    end
    req = 4'b0000;

    // HOLD_CYCLES=1 instance: one-cycle request gives a one-cycle grant.
    req1 = 4'b0100;
    step();
    req1 = 4'b0000;
    vectors++;
    if ({w1, En1, busy1} !== 4'b1011) begin
      errors++;
      $display("FAIL hold1_grant: got w=%b En=%b busy=%b, want w=10 En=1 busy=1", w1, En1, busy1);
    end
    step();
    vectors++;
    if ({w1, En1, busy1} !== 4'b1001) begin
      errors++;
      $display("FAIL hold1_release: got w=%b En=%b busy=%b, want w=10 En=0 busy=1", w1, En1, busy1);
    end
    step();
    vectors++;
    if ({En1, busy1} !== 2'b00) begin
      errors++;
      $display("FAIL hold1_idle: got En=%b busy=%b, want En=0 busy=0", En1, busy1);
    end
  endtask

  initial begin
    test_reset();
    test_single_early_done();
    test_full_contention();
    test_wrap_skip();
    test_drop_and_stuck();
    test_async_reset_and_hold1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
